// File: rtl/io_column_cfg.sv
// IO column on the fabric edge: routes pads to/from interconnect lines per tile,
// configured by a serially loaded shift register behind a start/valid/ready handshake.
module io_column_cfg #(
    parameter int TILES       = 3,
    parameter int IO_PER_TILE = 4,
    parameter int IC_PER_TILE = 6
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           cfg_start,
    input  logic                           cfg_valid,
    input  logic                           cfg_data,
    output logic                           cfg_ready,
    output logic                           cfg_done,
    input  logic [TILES*IO_PER_TILE-1:0]   data_from_io,
    output logic [TILES*IO_PER_TILE-1:0]   data_to_io,
    output logic [TILES*IO_PER_TILE-1:0]   io_oe,
    input  logic [TILES*IC_PER_TILE-1:0]   data_from_ic,
    output logic [TILES*IC_PER_TILE-1:0]   data_to_ic
);
    localparam int S_IC      = $clog2(IC_PER_TILE);
    localparam int S_IO      = $clog2(IO_PER_TILE);
    localparam int PAD_W     = S_IC + 2;
    localparam int LINE_W    = S_IO + 1;
    localparam int CFG_TILE  = IO_PER_TILE*PAD_W + IC_PER_TILE*LINE_W;
    localparam int CFG_TOTAL = TILES*CFG_TILE;
    localparam int CNT_W     = $clog2(CFG_TOTAL + 1);
    localparam int NIO       = TILES*IO_PER_TILE;
    localparam int NIC       = TILES*IC_PER_TILE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CFG_TOTAL-1:0] cfg_sr;
    logic                 accept;
    logic                 last_bit;
    logic                 active;

    logic [NIO-1:0]       pad_src, pad_oe, pad_reg;
    logic [NIC-1:0]       line_src, line_reg;
    logic [NIO-1:0]       q_out_p1;
    logic [NIC-1:0]       q_in_p1;

    // Out-of-range selects never match an index, so they yield 0.
    function automatic logic pick_ic(input logic [IC_PER_TILE-1:0] lines,
                                     input logic [S_IC-1:0]        sel);
        logic r;
        r = 1'b0;
        for (int i = 0; i < IC_PER_TILE; i++)
            if (sel == S_IC'(i)) r = lines[i];
        return r;
    endfunction

    function automatic logic pick_io(input logic [IO_PER_TILE-1:0] pads,
                                     input logic [S_IO-1:0]        sel);
        logic r;
        r = 1'b0;
        for (int i = 0; i < IO_PER_TILE; i++)
            if (sel == S_IO'(i)) r = pads[i];
        return r;
    endfunction

    assign cfg_ready = (state == LOAD);
    assign cfg_done  = (state == ACTIVE);
    assign active    = cfg_done;
    // A start pulse in LOAD wins over a simultaneous valid bit, which is dropped.
    assign accept    = cfg_valid & cfg_ready & ~cfg_start;
    assign last_bit  = (bit_cnt == CNT_W'(CFG_TOTAL - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cfg_start) state_next = LOAD;
            LOAD:    if (cfg_start) state_next = LOAD;
                     else if (accept && last_bit) state_next = ACTIVE;
            ACTIVE:  if (cfg_start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            cfg_sr  <= '0;
        end else begin
            state <= state_next;
            if (cfg_start)
                bit_cnt <= '0;
            else if (accept)
                bit_cnt <= bit_cnt + 1'b1;
            if (accept)
                cfg_sr <= {cfg_data, cfg_sr[CFG_TOTAL-1:1]};
        end
    end

    always_comb begin
        pad_src  = '0;
        pad_oe   = '0;
        pad_reg  = '0;
        line_src = '0;
        line_reg = '0;
        for (int t = 0; t < TILES; t++) begin
            for (int p = 0; p < IO_PER_TILE; p++) begin
                pad_src[t*IO_PER_TILE+p] = pick_ic(data_from_ic[t*IC_PER_TILE +: IC_PER_TILE],
                                                   cfg_sr[t*CFG_TILE + p*PAD_W +: S_IC]);
                pad_oe[t*IO_PER_TILE+p]  = cfg_sr[t*CFG_TILE + p*PAD_W + S_IC];
                pad_reg[t*IO_PER_TILE+p] = cfg_sr[t*CFG_TILE + p*PAD_W + S_IC + 1];
            end
            for (int i = 0; i < IC_PER_TILE; i++) begin
                line_src[t*IC_PER_TILE+i] = pick_io(data_from_io[t*IO_PER_TILE +: IO_PER_TILE],
                                                    cfg_sr[t*CFG_TILE + IO_PER_TILE*PAD_W + i*LINE_W +: S_IO]);
                line_reg[t*IC_PER_TILE+i] = cfg_sr[t*CFG_TILE + IO_PER_TILE*PAD_W + i*LINE_W + S_IO];
            end
        end
    end

    // ---- stage p1: optional path registers, held at 0 outside ACTIVE ----
    always_ff @(posedge clock) begin
        if (reset || !active) begin
            q_out_p1 <= '0;
            q_in_p1  <= '0;
        end else begin
            q_out_p1 <= pad_src;
            q_in_p1  <= line_src;
        end
    end

    assign data_to_io = active ? ((pad_reg & q_out_p1) | (~pad_reg & pad_src)) : '0;
    assign io_oe      = active ? pad_oe : '0;
    assign data_to_ic = active ? ((line_reg & q_in_p1) | (~line_reg & line_src)) : '0;

endmodule
